// File: rtl/mio_bus_slave.sv
// mio_bus_slave: responder end of the multi-cycle CPU memory/IO bus.
// Decodes requests into data RAM, LED/switch GPIO and a 32-bit compare timer,
// returns registered read data and a one-cycle MIO_ready after a per-region wait.
module mio_bus_slave #(
  parameter int unsigned RAM_AW   = 6,
  parameter int unsigned WAIT_RAM = 2,
  parameter int unsigned WAIT_IO  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_wr,
  output logic [31:0] Data_rd,
  output logic        MIO_ready,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        INT_out
);

  localparam int unsigned DW        = 32;
  localparam int unsigned IOW       = 16;
  localparam int unsigned WCW       = 4;
  localparam int unsigned RAM_WORDS = 1 << RAM_AW;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;
  typedef enum logic [2:0] {RG_RAM, RG_LED, RG_SW, RG_CNT, RG_CMP, RG_STAT, RG_NONE} region_e;

  state_e            state_q, state_d;
  region_e           region_q, region_d, region_c, sel_region_c;
  logic [WCW-1:0]    wcnt_q, wcnt_d, wload_c;
  logic [RAM_AW-1:0] idx_q, idx_d, sel_idx_c;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic [DW-1:0]     rdata_q, rdata_d, rmux_c;
  logic [IOW-1:0]    led_q, led_d;
  logic [DW-1:0]     count_q, count_d;
  logic [DW-1:0]     cmp_q, cmp_d;
  logic              irq_q, irq_d;
  logic              commit_c;
  logic [DW-1:0]     ram_q [RAM_WORDS];
  logic              unused_addr_lsb;

  // Byte-lane bits carry no meaning on this word-wide bus.
  assign unused_addr_lsb = ^Addr_in[1:0];

  // Address decode of the live request; IO registers need an exact word match.
  always_comb begin
    region_c = RG_NONE;
    if (Addr_in[DW-1:RAM_AW+2] == '0) begin
      region_c = RG_RAM;
    end else begin
      case (Addr_in[DW-1:2])
        30'h3C00_0000: region_c = RG_LED;
        30'h3C00_0001: region_c = RG_SW;
        30'h3800_0000: region_c = RG_CNT;
        30'h3800_0001: region_c = RG_CMP;
        30'h3800_0002: region_c = RG_STAT;
        default:       region_c = RG_NONE;
      endcase
    end
  end

  assign wload_c = (region_c == RG_RAM) ? WCW'(WAIT_RAM) : WCW'(WAIT_IO);

  // Read source for the access about to enter DONE (live request when idle).
  always_comb begin
    sel_region_c = (state_q == ST_IDLE) ? region_c : region_q;
    sel_idx_c    = (state_q == ST_IDLE) ? Addr_in[RAM_AW+1:2] : idx_q;
    rmux_c       = '0;
    case (sel_region_c)
      RG_RAM:  rmux_c = ram_q[sel_idx_c];
      RG_LED:  rmux_c = DW'(led_q);
      RG_SW:   rmux_c = DW'(sw_in);
      RG_CNT:  rmux_c = count_q;
      RG_CMP:  rmux_c = cmp_q;
      RG_STAT: rmux_c = DW'(irq_q);
      default: rmux_c = '0;
    endcase
  end

  // Bus FSM next state: latch request, count wait cycles, pulse ready in DONE.
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    wcnt_d   = wcnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    ready_d  = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (CPU_MIO) begin
          region_d = region_c;
          idx_d    = Addr_in[RAM_AW+1:2];
          wdata_d  = Data_wr;
          we_d     = mem_w;
          wcnt_d   = wload_c;
          if (wload_c == '0) begin
            state_d = ST_DONE;
            ready_d = 1'b1;
            if (!mem_w) rdata_d = rmux_c;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        wcnt_d = wcnt_q - WCW'(1);
        if (wcnt_q == WCW'(1)) begin
          state_d = ST_DONE;
          ready_d = 1'b1;
          if (!we_q) rdata_d = rmux_c;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Writes take effect at the edge that ends DONE.
  assign commit_c = (state_q == ST_DONE) && we_q;

  // Timer, compare, irq flag and LED register updates; irq set beats clear.
  always_comb begin
    count_d = count_q + DW'(1);
    cmp_d   = cmp_q;
    led_d   = led_q;
    irq_d   = irq_q;
    if (commit_c) begin
      case (region_q)
        RG_LED:  led_d   = wdata_q[IOW-1:0];
        RG_CNT:  count_d = wdata_q;
        RG_CMP:  cmp_d   = wdata_q;
        RG_STAT: if (wdata_q[0]) irq_d = 1'b0;
        default: ;
      endcase
    end
    if (count_q == cmp_q) irq_d = 1'b1;
  end

  // Data RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_c && (region_q == RG_RAM)) ram_q[idx_q] <= wdata_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      region_q <= RG_NONE;
      wcnt_q   <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      led_q    <= '0;
      count_q  <= '0;
      cmp_q    <= '1;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      wcnt_q   <= wcnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      led_q    <= led_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      irq_q    <= irq_d;
    end
  end

  assign Data_rd   = rdata_q;
  assign MIO_ready = ready_q;
  assign led_out   = led_q;
  assign INT_out   = irq_q;

endmodule

// File: tb/tb_mio_bus_slave.sv
// Bench for mio_bus_slave: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mio_bus_slave;

  localparam int unsigned RAM_AW   = 6;
  localparam int unsigned WAIT_RAM = 2;
  localparam int unsigned WAIT_IO  = 0;
  localparam int unsigned WORDS    = 1 << RAM_AW;

  logic        clk, reset, CPU_MIO, mem_w, MIO_ready, INT_out;
  logic [31:0] Addr_in, Data_wr, Data_rd;
  logic [15:0] sw_in, led_out;

  int total, bad;

  // Reference model state
  logic [31:0] m_ram [WORDS];
  logic [31:0] m_count, m_cmp, m_rdata;
  logic [15:0] m_led;
  logic        m_irq, m_ready;
  logic        busy, t_we;
  int          cyc, done_at;
  logic [31:0] t_addr, t_data;

  mio_bus_slave #(.RAM_AW(RAM_AW), .WAIT_RAM(WAIT_RAM), .WAIT_IO(WAIT_IO)) dut (
    .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
    .Addr_in(Addr_in), .Data_wr(Data_wr), .Data_rd(Data_rd),
    .MIO_ready(MIO_ready), .sw_in(sw_in), .led_out(led_out), .INT_out(INT_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_ram(input logic [31:0] a);
    return a[31:RAM_AW+2] == '0;
  endfunction

  function automatic int wait_of(input logic [31:0] a);
    return is_ram(a) ? int'(WAIT_RAM) : int'(WAIT_IO);
  endfunction

  function automatic logic [31:0] read_val(input logic [31:0] a, input logic [31:0] cnt,
                                           input logic [31:0] cmp, input logic irq);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (is_ram(a)) return m_ram[a[RAM_AW+1:2]];
    case (w)
      32'hF000_0000: return {16'h0, m_led};
      32'hF000_0004: return {16'h0, sw_in};
      32'hE000_0000: return cnt;
      32'hE000_0004: return cmp;
      32'hE000_0008: return {31'h0, irq};
      default:       return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    busy    = 1'b0;
    m_ready = 1'b0;
    m_rdata = '0;
    m_led   = '0;
    m_count = '0;
    m_cmp   = 32'hFFFF_FFFF;
    m_irq   = 1'b0;
  endtask

  // One clock edge of the model: a request accepted at edge k completes at
  // edge k+wait and its write lands one edge later.
  task automatic model_step();
    logic [31:0] old_cnt, old_cmp, w;
    logic        old_irq, was_busy, commit;
    if (!reset) begin
      model_reset();
      return;
    end
    cyc++;
    old_cnt  = m_count;
    old_cmp  = m_cmp;
    old_irq  = m_irq;
    was_busy = busy;
    commit   = busy && (cyc == done_at + 1);
    if (commit) busy = 1'b0;
    if (!was_busy && CPU_MIO) begin
      busy    = 1'b1;
      done_at = cyc + wait_of(Addr_in);
      t_addr  = Addr_in;
      t_data  = Data_wr;
      t_we    = mem_w;
    end
    m_ready = busy && (cyc == done_at);
    if (m_ready && !t_we) m_rdata = read_val(t_addr, old_cnt, old_cmp, old_irq);
    m_count = old_cnt + 32'd1;
    w = {t_addr[31:2], 2'b00};
    if (commit && t_we) begin
      if (is_ram(t_addr)) m_ram[t_addr[RAM_AW+1:2]] = t_data;
      else if (w == 32'hF000_0000) m_led = t_data[15:0];
      else if (w == 32'hE000_0000) m_count = t_data;
      else if (w == 32'hE000_0004) m_cmp = t_data;
      else if (w == 32'hE000_0008 && t_data[0]) m_irq = 1'b0;
    end
    if (old_cnt == old_cmp) m_irq = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of all DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    chk("MIO_ready", 32'(MIO_ready), 32'(m_ready));
    chk("Data_rd", Data_rd, m_rdata);
    chk("led_out", 32'(led_out), 32'(m_led));
    chk("INT_out", 32'(INT_out), 32'(m_irq));
  end

  // CPU-side bus access; lat = edges from request to observed MIO_ready.
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                     input bit drop_ok, output logic [31:0] rd, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    rd  = '0;
    @(posedge clk); #2;
    CPU_MIO = 1'b1; mem_w = we; Addr_in = addr; Data_wr = data;
    while (!got && lat < 64) begin
      @(posedge clk); lat++; #1;
      if (MIO_ready) begin
        got = 1'b1;
        rd  = Data_rd;
      end else if (drop_ok && lat == 1 && $urandom_range(0, 1) == 1) begin
        CPU_MIO = 1'b0; mem_w = 1'($urandom); Addr_in = $urandom; Data_wr = $urandom;
      end
    end
    #1; CPU_MIO = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL bus_timeout: addr %h no MIO_ready within %0d cycles", addr, lat);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (!MIO_ready && n < 64);
    if (!MIO_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: no MIO_ready within %0d cycles", n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, addr, data;
    logic [31:0] unm [6];
    logic        we;
    int          lat, n, sel;
    unm = '{32'h8000_0000, 32'hF000_0008, 32'h0000_0100,
            32'hE000_000C, 32'hFFFF_FFFC, 32'hDFFF_FFFC};
    total = 0; bad = 0; cyc = 0; done_at = 0;
    t_addr = '0; t_data = '0; t_we = 1'b0;
    CPU_MIO = 1'b0; mem_w = 1'b0; Addr_in = '0; Data_wr = '0; sw_in = '0;
    reset = 1'b1;
    model_reset();
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    chk("rst_Data_rd", Data_rd, 32'h0);
    chk("rst_ready", 32'(MIO_ready), 32'h0);
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_int", 32'(INT_out), 32'h0);

    // RAM write/read with WAIT_RAM=2
    bus(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, rd, lat);
    chk("ram_wr_lat", 32'(lat), 32'd3);
    bus(1'b0, 32'h0000_0010, 32'h0, 1'b0, rd, lat);
    chk("ram_rd_lat", 32'(lat), 32'd3);
    chk("ram_rd_data", rd, 32'h1234_5678);

    // LED write and switch read
    bus(1'b1, 32'hF000_0000, 32'hABCD_00FF, 1'b0, rd, lat);
    @(posedge clk); #2;
    chk("led_val", 32'(led_out), 32'h0000_00FF);
    sw_in = 16'hA5A5;
    bus(1'b0, 32'hF000_0004, 32'h0, 1'b0, rd, lat);
    chk("sw_lat", 32'(lat), 32'd1);
    chk("sw_data", rd, 32'h0000_A5A5);

    // Timer compare interrupt and status clear
    bus(1'b1, 32'hE000_0000, 32'h0000_1000, 1'b0, rd, lat);
    bus(1'b1, 32'hE000_0004, 32'd20, 1'b0, rd, lat);
    bus(1'b1, 32'hE000_0008, 32'h1, 1'b0, rd, lat);
    bus(1'b1, 32'hE000_0000, 32'd10, 1'b0, rd, lat);
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (!INT_out && n < 40);
    chk("irq_delay", 32'(n), 32'd11);
    bus(1'b1, 32'hE000_0008, 32'h1, 1'b0, rd, lat);
    @(posedge clk); #2;
    chk("irq_cleared", 32'(INT_out), 32'h0);
    bus(1'b0, 32'hE000_0008, 32'h0, 1'b0, rd, lat);
    chk("status_rd", rd, 32'h0);

    // Counter wrap
    bus(1'b1, 32'hE000_0000, 32'hFFFF_FFFE, 1'b0, rd, lat);
    bus(1'b0, 32'hE000_0000, 32'h0, 1'b0, rd, lat);
    chk("cnt_rd1", rd, 32'hFFFF_FFFE);
    bus(1'b0, 32'hE000_0000, 32'h0, 1'b0, rd, lat);
    chk("cnt_rd2", rd, 32'h0000_0000);
    chk("wrap_no_irq", 32'(INT_out), 32'h0);

    // Unmapped access
    bus(1'b0, 32'h0000_0010, 32'h0, 1'b0, rd, lat);
    chk("pre_unm_rd", rd, 32'h1234_5678);
    bus(1'b0, 32'h8000_0000, 32'h0, 1'b0, rd, lat);
    chk("unm_lat", 32'(lat), 32'd1);
    chk("unm_rd", rd, 32'h0);
    bus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, rd, lat);
    @(posedge clk); #2;
    chk("unm_led", 32'(led_out), 32'h0000_00FF);
    bus(1'b0, 32'h0000_0010, 32'h0, 1'b0, rd, lat);
    chk("unm_ram", rd, 32'h1234_5678);

    // Reset in the middle of a RAM write to word 3
    bus(1'b1, 32'h0000_000C, 32'h3333_3333, 1'b0, rd, lat);
    bus(1'b0, 32'h0000_000C, 32'h0, 1'b0, rd, lat);
    @(posedge clk); #2;
    CPU_MIO = 1'b1; mem_w = 1'b1; Addr_in = 32'h0000_000C; Data_wr = 32'hDEAD_BEEF;
    @(posedge clk); #2;
    reset = 1'b0; CPU_MIO = 1'b0;
    model_reset();
    #1;
    chk("abort_Data_rd", Data_rd, 32'h0);
    chk("abort_led", 32'(led_out), 32'h0);
    chk("abort_int", 32'(INT_out), 32'h0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort_no_ready", 32'(MIO_ready), 32'h0);
    end
    #1 reset = 1'b1;
    bus(1'b0, 32'h0000_000C, 32'h0, 1'b0, rd, lat);
    chk("abort_word3", rd, 32'h3333_3333);

    // Back-to-back reads with CPU_MIO held high
    bus(1'b1, 32'h0000_0014, 32'h5555_AAAA, 1'b0, rd, lat);
    @(posedge clk); #2;
    CPU_MIO = 1'b1; mem_w = 1'b0; Addr_in = 32'h0000_0014;
    wait_ready(n);
    wait_ready(n);
    chk("b2b_gap", 32'(n), 32'(WAIT_RAM + 2));
    chk("b2b_data", Data_rd, 32'h5555_AAAA);
    #1 CPU_MIO = 1'b0;

    // Fill RAM, then random traffic
    for (int i = 0; i < int'(WORDS); i++) begin
      bus(1'b1, 32'(i) << 2, $urandom, 1'b0, rd, lat);
      chk("fill_lat", 32'(lat), 32'(WAIT_RAM + 1));
    end
    for (int k = 0; k < 500; k++) begin
      sel  = int'($urandom_range(0, 9));
      we   = 1'($urandom);
      data = $urandom;
      if ($urandom_range(0, 3) == 0) sw_in = 16'($urandom);
      case (sel)
        0, 1, 2, 3: addr = (32'($urandom_range(0, WORDS - 1)) << 2) | 32'($urandom_range(0, 3));
        4: addr = 32'hF000_0000 | 32'($urandom_range(0, 3));
        5: addr = 32'hF000_0004;
        6: begin addr = 32'hE000_0000; data = m_cmp - 32'($urandom_range(2, 30)); end
        7: begin addr = 32'hE000_0004; data = m_count + 32'($urandom_range(2, 30)); end
        8: addr = 32'hE000_0008;
        default: addr = unm[$urandom_range(0, 5)];
      endcase
      bus(we, addr, data, 1'b1, rd, lat);
      chk("rand_lat", 32'(lat), 32'(wait_of(addr) + 1));
    end

    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
